// File: rtl/reorder_trace_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : reorder_trace_scheduler_pkg
//  Purpose  : Shared definitions for the re-order trace scheduler: width
//             helper and the two-state scheduler encoding.
//  Revision : 1.0  initial release
// ============================================================================
package reorder_trace_scheduler_pkg;

    // Width of an index able to address v entries (never narrower than 1 bit).
    function automatic int clog2(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

    // Scheduler states: IDLE arbitrates new transactions, LOCKED holds the
    // port for one lane until its trace ends.
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } sched_state_e;

endpackage
`default_nettype wire

// File: rtl/reorder_trace_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : reorder_rr_arbiter
//  Purpose  : Combinational round-robin arbiter. Searches the request vector
//             starting at ptr+1 (wrapping) and returns a one-hot grant, the
//             granted index and a valid flag.
//  Revision : 1.0  initial release
// ============================================================================
module reorder_rr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int IDX_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]   req_i,
    input  logic [IDX_WIDTH-1:0] ptr_i,
    output logic [NUM_REQ-1:0]   grant_o,
    output logic [IDX_WIDTH-1:0] idx_o,
    output logic                 valid_o
);

    int                 cand;
    logic [IDX_WIDTH-1:0] cand_idx;
    logic               found;

    // First requesting lane after the pointer wins; the pointer lane is last.
    always_comb begin
        grant_o  = '0;
        idx_o    = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand     = (int'(ptr_i) + off) % NUM_REQ;
            cand_idx = IDX_WIDTH'(cand);
            if (!found && req_i[cand_idx]) begin
                found             = 1'b1;
                grant_o[cand_idx] = 1'b1;
                idx_o             = cand_idx;
            end
        end
        valid_o = found;
    end

endmodule
`default_nettype wire

// File: rtl/reorder_trace_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : reorder_trace_scheduler
//  Purpose  : Arbitrates dispatch lanes onto the single trace/ID push port of
//             the re-order logic. Allocates sequential IDs, keeps one lane's
//             trace segments contiguous, tracks outstanding IDs against DEPTH
//             and turns an owner abort into a retroactive breakpoint update.
//  Revision : 1.0  initial release
// ============================================================================
module reorder_trace_scheduler
    import reorder_trace_scheduler_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int NUM_QUEUES = 4,
    parameter int DEPTH      = 64,
    parameter int ID_WIDTH   = clog2(DEPTH),
    parameter int SEL_WIDTH  = clog2(NUM_QUEUES)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    input  logic [NUM_REQ*SEL_WIDTH-1:0]   req_sel_i,
    input  logic [NUM_REQ-1:0]             req_last_i,
    input  logic [NUM_REQ-1:0]             req_abort_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    output logic [ID_WIDTH-1:0]            req_id_o,
    output logic                           trace_id_push_o,
    output logic [ID_WIDTH-1:0]            trace_id_value_o,
    output logic                           trace_push_o,
    output logic [SEL_WIDTH-1:0]           trace_sel_o,
    output logic                           trace_break_o,
    output logic                           trace_update_o,
    input  logic                           full_i,
    input  logic                           commit_valid_i,
    input  logic                           commit_pull_i,
    output logic [ID_WIDTH:0]              outstanding_o,
    output logic                           busy_o
);

    localparam int REQ_W = clog2(NUM_REQ);
    localparam int CNT_W = ID_WIDTH + 1;

    sched_state_e         state_q, state_d;
    logic [REQ_W-1:0]     ptr_q, ptr_d;
    logic [REQ_W-1:0]     owner_q, owner_d;
    logic [ID_WIDTH-1:0]  next_id_q, next_id_d;
    logic [ID_WIDTH-1:0]  cur_id_q, cur_id_d;
    logic [CNT_W-1:0]     outstanding_q, outstanding_d;

    logic [NUM_REQ-1:0]   arb_grant;
    logic [REQ_W-1:0]     arb_idx;
    logic                 arb_valid;

    logic [NUM_REQ-1:0]   ready;
    logic [REQ_W-1:0]     lane;
    logic [SEL_WIDTH-1:0] seg_sel;
    logic                 seg_last;
    logic                 can_alloc;
    logic                 accept;
    logic                 alloc;
    logic                 pull;
    logic                 update;

    reorder_rr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .IDX_WIDTH (REQ_W)
    ) u_arb (
        .req_i   (req_valid_i),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    // Next-state, counter updates and handshake decode for the current cycle.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        owner_d       = owner_q;
        next_id_d     = next_id_q;
        cur_id_d      = cur_id_q;
        outstanding_d = outstanding_q;
        ready         = '0;
        lane          = owner_q;
        alloc         = 1'b0;
        update        = 1'b0;
        can_alloc     = !full_i && (outstanding_q < CNT_W'(DEPTH));

        case (state_q)
            ST_IDLE: begin
                lane = arb_idx;
                if (arb_valid && can_alloc) begin
                    ready = arb_grant;
                end
            end
            ST_LOCKED: begin
                // Abort wins over a simultaneous valid and ignores full.
                if (req_abort_i[owner_q]) begin
                    update  = 1'b1;
                    state_d = ST_IDLE;
                end else if (!full_i) begin
                    ready[owner_q] = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        accept   = ready[lane] & req_valid_i[lane];
        seg_sel  = req_sel_i[int'(lane)*SEL_WIDTH +: SEL_WIDTH];
        seg_last = req_last_i[lane];

        if (accept) begin
            if (state_q == ST_IDLE) begin
                alloc     = 1'b1;
                next_id_d = next_id_q + 1'b1;
                ptr_d     = lane;
                if (!seg_last) begin
                    state_d  = ST_LOCKED;
                    owner_d  = lane;
                    cur_id_d = next_id_q;
                end
            end else if (seg_last) begin
                state_d = ST_IDLE;
            end
        end

        // Pull on an empty count is dropped so the counter cannot underflow.
        pull = commit_valid_i & commit_pull_i & (outstanding_q != '0);
        case ({alloc, pull})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    // State and counter registers; reset abandons any locked transaction.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            ptr_q         <= REQ_W'(NUM_REQ - 1);
            owner_q       <= '0;
            next_id_q     <= '0;
            cur_id_q      <= '0;
            outstanding_q <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            owner_q       <= owner_d;
            next_id_q     <= next_id_d;
            cur_id_q      <= cur_id_d;
            outstanding_q <= outstanding_d;
        end
    end

    // Outputs are forced low while reset is held, even the combinational ones.
    always_comb begin
        req_ready_o      = rst_i ? '0 : ready;
        req_id_o         = rst_i ? '0 : ((state_q == ST_LOCKED) ? cur_id_q : next_id_q);
        trace_id_push_o  = !rst_i && alloc;
        trace_id_value_o = (!rst_i && alloc) ? next_id_q : '0;
        trace_push_o     = !rst_i && accept;
        trace_sel_o      = (!rst_i && accept) ? seg_sel : '0;
        trace_break_o    = !rst_i && accept && seg_last;
        trace_update_o   = !rst_i && update;
        outstanding_o    = rst_i ? '0 : outstanding_q;
        busy_o           = !rst_i && (state_q == ST_LOCKED);
    end

endmodule
`default_nettype wire
